// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with stall and flush; define PIPE_STAGE_SKID_EN to add a skid entry (capacity 2)
`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus [1:0]
`endif
`ifndef CTRL_STATE_Stalled
`define CTRL_STATE_Stalled 2'd1
`endif
module pipe_stage_reg #(
   parameter int unsigned       DATA_W     = 96,
   parameter logic [DATA_W-1:0] RST_VAL    = '0,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic `CTRL_Wire_Bus ctrl_signal_i,
   input  logic                flush_i,
   input  logic                in_valid_i,
   input  logic [DATA_W-1:0]   in_data_i,
   output logic                in_ready_o,
   output logic                out_valid_o,
   output logic [DATA_W-1:0]   out_data_o,
   input  logic                out_ready_i,
   output logic [1:0]          occupancy_o
);
   logic              stall;
   logic              accept;
   logic              consume;
   logic              out_valid_d, out_valid_q;
   logic [DATA_W-1:0] out_data_d, out_data_q;
   assign stall       = ctrl_signal_i == `CTRL_STATE_Stalled;
   assign accept      = in_valid_i && in_ready_o;
   assign consume     = out_valid_q && out_ready_i && !stall;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid_d, skid_valid_q;
   logic [DATA_W-1:0] skid_data_d, skid_data_q;
   logic              in_ready_d, in_ready_q;
   logic              load;
   assign in_ready_o  = in_ready_q;
   assign occupancy_o = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
   assign load        = !out_valid_q || consume;
   // output refills from the skid entry before the input to keep FIFO order; a held output diverts input to skid
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         out_data_d   = BUBBLE_VAL;
         skid_valid_d = 1'b0;
      end else if (load) begin
         out_valid_d  = skid_valid_q || accept;
         out_data_d   = skid_valid_q ? skid_data_q : (accept ? in_data_i : out_data_q);
         skid_valid_d = 1'b0;
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data_i;
      end
      in_ready_d = !skid_valid_d;
   end
   // skid entry and registered ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= RST_VAL;
         in_ready_q   <= 1'b1;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end
`else
   assign in_ready_o  = !out_valid_q || (out_ready_i && !stall);
   assign occupancy_o = {1'b0, out_valid_q};
   // flush wins, then a new payload replaces any consumed one, else a consume empties the stage
   always_comb begin
      out_valid_d = flush_i ? 1'b0 : accept ? 1'b1 : consume ? 1'b0 : out_valid_q;
      out_data_d  = flush_i ? BUBBLE_VAL : accept ? in_data_i : out_data_q;
   end
`endif
   // output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= RST_VAL;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model bench for pipe_stage_reg with directed scenarios
`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus [1:0]
`endif
`ifndef CTRL_STATE_Stalled
`define CTRL_STATE_Stalled 2'd1
`endif
module tb_pipe_stage_reg;
   localparam int W = 96;
   localparam logic [W-1:0] RV = 96'h0000_0000_0000_0000_0000_0ABC;
   localparam logic [W-1:0] BV = 96'h0000_0000_0000_0000_0000_DEAD;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   logic                clk = 1'b0;
   logic                rst;
   logic `CTRL_Wire_Bus ctrl_signal_i;
   logic                flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
   logic [W-1:0]        in_data_i, out_data_o;
   logic [1:0]          occupancy_o;
   int                  errors = 0;
   int                  checks = 0;
   bit                  chk_en = 1'b0;
   logic [W-1:0]        mq[$];
   logic [W-1:0]        emitted[$];
   logic [W-1:0]        m_last = RV;
   bit                  m_acc, m_con;
   int                  cnt;

   pipe_stage_reg #(.DATA_W(W), .RST_VAL(RV), .BUBBLE_VAL(BV)) dut (
      .clk(clk), .rst(rst), .ctrl_signal_i(ctrl_signal_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
      .occupancy_o(occupancy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit m_ready();
      if (SKID) return mq.size() < 2;
      return mq.size() == 0 || (out_ready_i && ctrl_signal_i != `CTRL_STATE_Stalled);
   endfunction

   // behavioural model: a queue of held entries, head is the visible output
   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         mq.delete();
         m_last = RV;
      end else if (flush_i) begin
         mq.delete();
         m_last = BV;
      end else begin
         m_acc = in_valid_i && m_ready();
         m_con = mq.size() > 0 && out_ready_i && ctrl_signal_i != `CTRL_STATE_Stalled;
         if (m_con) emitted.push_back(mq.pop_front());
         if (m_acc) mq.push_back(in_data_i);
         if (mq.size() > 0) m_last = mq[0];
      end
   end

   // per-cycle comparison of every output against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("cyc_valid", W'(out_valid_o), W'(mq.size() != 0));
         chk("cyc_data", out_data_o, m_last);
         chk("cyc_occ", W'(occupancy_o), W'(mq.size()));
         chk("cyc_ready", W'(in_ready_o), W'(m_ready()));
      end
   end

   task automatic tick();
      logic a;
      @(negedge clk);
      a = in_valid_i && in_ready_o;
      @(posedge clk);
      #1;
      if (a) in_valid_i = 1'b0;
   endtask

   task automatic push(input logic [W-1:0] d);
      in_valid_i = 1'b1;
      in_data_i  = d;
      tick();
   endtask

   initial begin
      rst = 1'b0; ctrl_signal_i = 2'd0; flush_i = 1'b0;
      in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_valid", W'(out_valid_o), '0);
      chk("rst_data", out_data_o, RV);
      chk("rst_occ", W'(occupancy_o), '0);
      chk("rst_ready", W'(in_ready_o), W'(1));
      rst = 1'b1;
      chk_en = 1'b1;
      // single payload, latency 1
      out_ready_i = 1'b1;
      push(96'hA);
      chk("lat_data", out_data_o, 96'hA);
      chk("lat_valid", W'(out_valid_o), W'(1));
      chk("lat_occ", W'(occupancy_o), W'(1));
      tick();
      // stream then stall
      emitted.delete();
      ctrl_signal_i = 2'd3;
      push(96'h1);
      push(96'h2);
      chk("strm_data", out_data_o, 96'h2);
      ctrl_signal_i = `CTRL_STATE_Stalled;
      in_valid_i = 1'b1;
      in_data_i  = 96'h3;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold", out_data_o, 96'h2);
         chk("stall_valid", W'(out_valid_o), W'(1));
      end
      ctrl_signal_i = 2'd0;
      tick();
      chk("release_data", out_data_o, 96'h3);
      in_valid_i = 1'b0;
      tick();
      tick();
      chk("order_n", W'(emitted.size()), W'(3));
      for (int i = 0; i < 3; i++)
         chk("order", (i < emitted.size()) ? emitted[i] : '1, W'(i + 1));
      // flush beats stall and acceptance
      emitted.delete();
      out_ready_i = 1'b0;
      push(96'h77);
      ctrl_signal_i = `CTRL_STATE_Stalled;
      flush_i = 1'b1;
      push(96'h55);
      chk("flush_valid", W'(out_valid_o), '0);
      chk("flush_data", out_data_o, BV);
      chk("flush_occ", W'(occupancy_o), '0);
      flush_i = 1'b0; ctrl_signal_i = 2'd0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      repeat (3) tick();
      cnt = 0;
      foreach (emitted[i]) if (emitted[i] == 96'h55 || emitted[i] == 96'h77) cnt++;
      chk("flush_drop", W'(cnt), '0);
      emitted.delete();
`ifdef PIPE_STAGE_SKID_EN
      out_ready_i = 1'b0;
      push(96'h11);
      push(96'h22);
      chk("skid_occ", W'(occupancy_o), W'(2));
      chk("skid_ready", W'(in_ready_o), '0);
      out_ready_i = 1'b1;
      tick();
      chk("skid_next", out_data_o, 96'h22);
      tick();
      chk("skid_n", W'(emitted.size()), W'(2));
      chk("skid_first", (emitted.size() > 0) ? emitted[0] : '1, 96'h11);
      chk("skid_second", (emitted.size() > 1) ? emitted[1] : '1, 96'h22);
      chk("skid_empty", W'(out_valid_o), '0);
`else
      out_ready_i = 1'b0;
      push(96'h33);
      chk("ns_occ", W'(occupancy_o), W'(1));
      in_valid_i = 1'b1;
      in_data_i  = 96'h44;
      #1;
      chk("ns_notready", W'(in_ready_o), '0);
      tick();
      chk("ns_hold", out_data_o, 96'h33);
      out_ready_i = 1'b1;
      #1;
      chk("ns_ready", W'(in_ready_o), W'(1));
      tick();
      chk("ns_swap_occ", W'(occupancy_o), W'(1));
      chk("ns_swap_data", out_data_o, 96'h44);
      in_valid_i = 1'b0;
      tick();
`endif
      // asynchronous reset between edges with the stage full
      out_ready_i = 1'b0;
      push(96'h81);
`ifdef PIPE_STAGE_SKID_EN
      push(96'h82);
`endif
      chk("full_occ", W'(occupancy_o), SKID ? W'(2) : W'(1));
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", W'(out_valid_o), '0);
      chk("arst_data", out_data_o, RV);
      chk("arst_occ", W'(occupancy_o), '0);
      chk("arst_ready", W'(in_ready_o), W'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      out_ready_i = 1'b1;
      push(96'h66);
      chk("post_rst_data", out_data_o, 96'h66);
      chk("post_rst_occ", W'(occupancy_o), W'(1));
      tick();
      tick();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
